// File: rtl/fir_decimator.sv
// Half-band 7-tap FIR low-pass with decimation by 2 for signed PCM samples.
// One sequential multiplier; every output appears exactly 9 cycles after the triggering sample.
module fir_decimator #(
  parameter int WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic                    audio_sample_valid,
  output logic signed [WIDTH-1:0] dec_output,
  output logic                    dec_output_ready
);

  localparam int TAPS   = 7;
  localparam int COEF_W = 6;
  localparam int PROD_W = WIDTH + COEF_W;
  localparam int ACC_W  = WIDTH + 8;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_SAT,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [WIDTH-1:0]  r_dl   [0:TAPS-1];
  logic signed [WIDTH-1:0]  r_snap [0:TAPS-1];
  logic                     r_phase;
  logic [2:0]               r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [WIDTH-1:0]  r_sat;

  logic                     w_busy;
  logic                     w_accept;
  logic                     w_trigger;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [WIDTH-1:0]  w_tap_sample;
  logic signed [PROD_W-1:0] w_product;
  logic signed [ACC_W-1:0]  w_product_ext;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [WIDTH-1:0]  w_sat_val;

  assign w_busy    = (r_state != S_IDLE);
  assign w_accept  = audio_sample_valid && !w_busy;
  assign w_trigger = w_accept && r_phase;

  // Coefficient ROM and tap select share the same index.
  always_comb begin
    w_coef       = '0;
    w_tap_sample = '0;
    case (r_tap)
      3'd0: begin w_coef = -6'sd1; w_tap_sample = r_snap[0]; end
      3'd1: begin w_coef =  6'sd0; w_tap_sample = r_snap[1]; end
      3'd2: begin w_coef =  6'sd9; w_tap_sample = r_snap[2]; end
      3'd3: begin w_coef =  6'sd16; w_tap_sample = r_snap[3]; end
      3'd4: begin w_coef =  6'sd9; w_tap_sample = r_snap[4]; end
      3'd5: begin w_coef =  6'sd0; w_tap_sample = r_snap[5]; end
      3'd6: begin w_coef = -6'sd1; w_tap_sample = r_snap[6]; end
      default: begin w_coef = '0; w_tap_sample = '0; end
    endcase
  end

  assign w_product     = w_coef * w_tap_sample;
  assign w_product_ext = {{(ACC_W-PROD_W){w_product[PROD_W-1]}}, w_product};
  assign w_shifted     = r_acc >>> 5;

  always_comb begin
    w_sat_val = w_shifted[WIDTH-1:0];
    if (w_shifted > SAT_MAX) begin
      w_sat_val = SAT_MAX[WIDTH-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat_val = SAT_MIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // IDLE -> MAC (7 taps) -> SAT -> OUT gives the fixed 9-cycle latency.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_state_next = S_MAC;
      S_MAC:   if (r_tap == 3'd6) w_state_next = S_SAT;
      S_SAT:   w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Snapshot captures the delay line as it will look after this shift.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < TAPS; i++) begin
        r_dl[i]   <= '0;
        r_snap[i] <= '0;
      end
    end else if (w_accept) begin
      r_dl[0] <= audio_in;
      for (int i = 1; i < TAPS; i++) begin
        r_dl[i] <= r_dl[i-1];
      end
      if (w_trigger) begin
        r_snap[0] <= audio_in;
        for (int i = 1; i < TAPS; i++) begin
          r_snap[i] <= r_dl[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_phase          <= 1'b0;
      r_tap            <= '0;
      r_acc            <= '0;
      r_sat            <= '0;
      dec_output       <= '0;
      dec_output_ready <= 1'b0;
    end else begin
      dec_output_ready <= 1'b0;
      if (w_accept) begin
        r_phase <= ~r_phase;
      end
      if (w_trigger) begin
        r_acc <= '0;
        r_tap <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= r_acc + w_product_ext;
        r_tap <= r_tap + 3'd1;
      end
      if (r_state == S_SAT) begin
        r_sat <= w_sat_val;
      end
      if (r_state == S_OUT) begin
        dec_output       <= r_sat;
        dec_output_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: impulses, DC, saturation, busy and reset behaviour.
// Samples are spaced 32 cycles apart; each window checks latency, pulse width and held output.
module tb_fir_decimator;

  localparam logic signed [15:0] SMAX = 16'sh7FFF;
  localparam logic signed [15:0] SMIN = 16'sh8000;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic signed [15:0]  audio_in;
  logic                audio_sample_valid;
  logic signed [15:0]  dec_output;
  logic                dec_output_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [15:0] last_out;
  logic signed [15:0] xs [8];
  logic signed [15:0] ys [4];

  fir_decimator #(.WIDTH(16)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .audio_in          (audio_in),
    .audio_sample_valid(audio_sample_valid),
    .dec_output        (dec_output),
    .dec_output_ready  (dec_output_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reset is held with a valid sample present; the sample must be discarded.
  task automatic do_reset(input string tag);
    rst_in = 1'b1;
    audio_sample_valid = 1'b1;
    audio_in = 16'sd12345;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    audio_sample_valid = 1'b0;
    audio_in = '0;
    last_out = '0;
    check({tag, "_rst_out"}, dec_output, 0);
    check({tag, "_rst_rdy"}, {31'd0, dec_output_ready}, 0);
  endtask

  // One 32-cycle sample window, optionally injecting a valid or a reset at cycle k.
  task automatic feed(input logic signed [15:0] s, input bit trig, input logic signed [15:0] exp_y,
                      input string tag, input int inj_at, input logic signed [15:0] inj_val,
                      input int rst_at);
    int lat;
    int pulses;
    logic signed [15:0] seen;
    lat = 0;
    pulses = 0;
    seen = '0;
    audio_in = s;
    audio_sample_valid = 1'b1;
    @(posedge clk_in);
    #1;
    audio_sample_valid = 1'b0;
    audio_in = '0;
    for (int k = 1; k < 32; k++) begin
      if (k == inj_at) begin
        audio_in = inj_val;
        audio_sample_valid = 1'b1;
      end
      if (k == rst_at) rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      audio_sample_valid = 1'b0;
      audio_in = '0;
      rst_in = 1'b0;
      if (dec_output_ready === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          seen = dec_output;
        end
      end
    end
    if (rst_at != 0) begin
      check({tag, "_pulses"}, pulses, 0);
      check({tag, "_out"}, dec_output, 0);
      last_out = '0;
    end else if (trig) begin
      check({tag, "_lat"}, lat, 9);
      check({tag, "_pulses"}, pulses, 1);
      check({tag, "_val"}, seen, exp_y);
      check({tag, "_hold"}, dec_output, exp_y);
      last_out = exp_y;
    end else begin
      check({tag, "_pulses"}, pulses, 0);
      check({tag, "_hold"}, dec_output, last_out);
    end
  endtask

  task automatic run_seq(input string tag);
    do_reset(tag);
    for (int i = 0; i < 8; i++) begin
      feed(xs[i], (i % 2) == 1, ys[i/2], $sformatf("%s_%0d", tag, i), 0, '0, 0);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    audio_sample_valid = 1'b0;
    audio_in = '0;
    last_out = '0;
    repeat (3) @(posedge clk_in);
    #1;

    xs = '{16'sd0, 16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    ys = '{-16'sd32, 16'sd281, 16'sd281, -16'sd32};
    run_seq("odd");
    feed(16'sd0, 1'b0, 16'sd0, "odd_8", 0, '0, 0);
    feed(16'sd0, 1'b1, 16'sd0, "odd_9", 0, '0, 0);

    xs = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    ys = '{16'sd0, 16'sd500, 16'sd0, 16'sd0};
    run_seq("even");

    xs = '{16'sd3200, 16'sd3200, 16'sd3200, 16'sd3200, 16'sd3200, 16'sd3200, 16'sd3200, 16'sd3200};
    ys = '{-16'sd100, 16'sd2400, 16'sd3300, 16'sd3200};
    run_seq("dcpos");

    xs = '{SMIN, SMIN, SMIN, SMIN, SMIN, SMIN, SMIN, SMIN};
    ys = '{16'sd1024, -16'sd24576, SMIN, SMIN};
    run_seq("dcneg");

    xs = '{16'sd0, SMIN, 16'sd0, SMAX, SMAX, SMAX, 16'sd0, SMIN};
    ys = '{16'sd1024, -16'sd10240, -16'sd1025, SMAX};
    run_seq("satp");

    xs = '{16'sd0, SMAX, 16'sd0, SMIN, SMIN, SMIN, 16'sd0, SMAX};
    ys = '{-16'sd1024, 16'sd10239, 16'sd1023, SMIN};
    run_seq("satn");

    // A valid 3 cycles after the trigger must leave data and phase untouched.
    do_reset("busy");
    feed(16'sd1000, 1'b0, 16'sd0, "busy_0", 0, '0, 0);
    feed(16'sd0, 1'b1, 16'sd0, "busy_1", 3, 16'sd5000, 0);
    feed(16'sd0, 1'b0, 16'sd0, "busy_2", 0, '0, 0);
    feed(16'sd0, 1'b1, 16'sd500, "busy_3", 0, '0, 0);

    // Reset 4 cycles into a computation aborts it and clears the delay line.
    do_reset("abort");
    feed(16'sd1000, 1'b0, 16'sd0, "abort_0", 0, '0, 0);
    feed(16'sd2000, 1'b1, 16'sd0, "abort_1", 0, '0, 4);
    feed(16'sd0, 1'b0, 16'sd0, "abort_2", 0, '0, 0);
    feed(16'sd1000, 1'b1, -16'sd32, "abort_3", 0, '0, 0);
    feed(16'sd0, 1'b0, 16'sd0, "abort_4", 0, '0, 0);
    feed(16'sd0, 1'b1, 16'sd281, "abort_5", 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
